// File: rtl/mips_regfile_sb_pkg.sv
// Shared defaults, index/data types and well-known register numbers for the GPR file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

   localparam int REG_ZERO = 0;
   localparam int REG_V0   = 2;
endpackage

// File: rtl/mips_regfile_sb_if.sv
// Decode/writeback-facing bus of the GPR file: read ports, two write ports, reserve and debug taps.
interface mips_regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_idx;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pend;
   logic                     wa_en;
   logic [ADDR_W-1:0]        wa_idx;
   logic [DATA_W-1:0]        wa_data;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_idx;
   logic [DATA_W-1:0]        wb_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_idx;
   logic [7:0]               err_r0_cnt;
   logic [DATA_W-1:0]        reg_v0;

   modport master (
      output rd_idx, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data, rsv_en, rsv_idx,
      input  rd_data, rd_pend, err_r0_cnt, reg_v0
   );

   modport slave (
      input  rd_idx, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data, rsv_en, rsv_idx,
      output rd_data, rd_pend, err_r0_cnt, reg_v0
   );
endinterface

// File: rtl/mips_regfile_sb_scoreboard.sv
// Per-register pending bits: reserve sets, either write port clears, reserve wins a tie; r0 never pends.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_idx,
   input  logic                     clr_a_en,
   input  logic [ADDR_W-1:0]        clr_a_idx,
   input  logic                     clr_b_en,
   input  logic [ADDR_W-1:0]        clr_b_idx,
   input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
   output logic [NUM_RD-1:0]        rd_pend
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend_reg;
   logic [DEPTH-1:0] pend_next;

   assign pend_next[REG_ZERO] = 1'b0;

   for (genvar gi = 1; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_idx == ADDR_W'(gi));
      assign clr_hit = (clr_a_en && (clr_a_idx == ADDR_W'(gi))) ||
                       (clr_b_en && (clr_b_idx == ADDR_W'(gi)));
      assign pend_next[gi] = set_hit || (pend_reg[gi] && !clr_hit);
   end

   always_ff @(posedge clk) begin
      if (reset) pend_reg <= '0;
      else       pend_reg <= pend_next;
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      assign rd_pend[gi] = pend_reg[rd_idx[gi*ADDR_W +: ADDR_W]];
   end
endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS GPR file with r0 hardwired to zero, B-priority dual write, r0-write error counter and RAW scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module mips_regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) (
   input logic clk,
   input logic reset,
   mips_regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_reg [DEPTH];
   logic [7:0]        err_reg;
   logic [8:0]        err_sum;
   logic              wa_r0;
   logic              wb_r0;
   logic [NUM_RD-1:0] sb_pend;

   assign wa_r0 = bus.wa_en && (bus.wa_idx == ADDR_W'(REG_ZERO));
   assign wb_r0 = bus.wb_en && (bus.wb_idx == ADDR_W'(REG_ZERO));

   // Port B is written last so it overrides A on an index collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      end else begin
         if (bus.wa_en && !wa_r0) regs_reg[bus.wa_idx] <= bus.wa_data;
         if (bus.wb_en && !wb_r0) regs_reg[bus.wb_idx] <= bus.wb_data;
      end
   end

   assign err_sum = {1'b0, err_reg} + 9'(wa_r0) + 9'(wb_r0);

   always_ff @(posedge clk) begin
      if (reset)              err_reg <= '0;
      else if (err_sum > 255) err_reg <= 8'hFF;
      else                    err_reg <= err_sum[7:0];
   end

   assign bus.err_r0_cnt = err_reg;
   assign bus.reg_v0     = regs_reg[REG_V0];

   regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .set_en    (bus.rsv_en),
      .set_idx   (bus.rsv_idx),
      .clr_a_en  (bus.wa_en),
      .clr_a_idx (bus.wa_idx),
      .clr_b_en  (bus.wb_en),
      .clr_b_idx (bus.wb_idx),
      .rd_idx    (bus.rd_idx),
      .rd_pend   (sb_pend)
   );

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
      logic              pend;

      assign idx = bus.rd_idx[gi*ADDR_W +: ADDR_W];

      always_comb begin
         data = regs_reg[idx];
         pend = sb_pend[gi];
`ifdef REGFILE_BYPASS_EN
         if (bus.wb_en && (bus.wb_idx == idx)) begin
            data = bus.wb_data;
            pend = pend && bus.rsv_en && (bus.rsv_idx == idx);
         end else if (bus.wa_en && (bus.wa_idx == idx)) begin
            data = bus.wa_data;
            pend = pend && bus.rsv_en && (bus.rsv_idx == idx);
         end
`endif
         if (reset || (idx == ADDR_W'(REG_ZERO))) begin
            data = '0;
            pend = 1'b0;
         end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
      assign bus.rd_pend[gi]                  = pend;
   end
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Randomised and directed checks of mips_regfile_sb against an array/bit-vector reference model.
module tb_mips_regfile_sb;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DW-1:0] model [DEPTH];
   bit            pend_m [DEPTH];
   int            err_m;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] idx);
      if (reset || idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (bus.wb_en && bus.wb_idx == idx) return bus.wb_data;
      if (bus.wa_en && bus.wa_idx == idx) return bus.wa_data;
`endif
      return model[idx];
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] idx);
      if (reset || idx == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (((bus.wb_en && bus.wb_idx == idx) || (bus.wa_en && bus.wa_idx == idx)) &&
          !(bus.rsv_en && bus.rsv_idx == idx)) return 1'b0;
`endif
      return pend_m[idx];
   endfunction

   task automatic idle();
      bus.wa_en  = 1'b0;
      bus.wb_en  = 1'b0;
      bus.rsv_en = 1'b0;
   endtask

   task automatic set_rd(input int k, input int idx);
      bus.rd_idx[k*AW +: AW] = AW'(idx);
   endtask

   // One clock: check every output mid-cycle, then apply the edge to the model.
   task automatic cycle();
      int sum;
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
         logic [AW-1:0] idx;
         idx = bus.rd_idx[k*AW +: AW];
         chk($sformatf("rd_data%0d[r%0d]", k, idx), 64'(bus.rd_data[k*DW +: DW]), 64'(exp_data(idx)));
         chk($sformatf("rd_pend%0d[r%0d]", k, idx), 64'(bus.rd_pend[k]), 64'(exp_pend(idx)));
      end
      chk("err_r0_cnt", 64'(bus.err_r0_cnt), 64'(err_m));
      chk("reg_v0", 64'(bus.reg_v0), 64'(model[2]));
      $display("cyc %0d rst=%0b wa=%0b r%0d=%h wb=%0b r%0d=%h rsv=%0b r%0d", cyc, reset,
               bus.wa_en, bus.wa_idx, bus.wa_data, bus.wb_en, bus.wb_idx, bus.wb_data,
               bus.rsv_en, bus.rsv_idx);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            model[i]  = '0;
            pend_m[i] = 1'b0;
         end
         err_m = 0;
      end else begin
         sum = 0;
         if (bus.wa_en) begin
            if (bus.wa_idx == 0) sum++;
            else begin model[bus.wa_idx] = bus.wa_data; pend_m[bus.wa_idx] = 1'b0; end
         end
         if (bus.wb_en) begin
            if (bus.wb_idx == 0) sum++;
            else begin model[bus.wb_idx] = bus.wb_data; pend_m[bus.wb_idx] = 1'b0; end
         end
         if (bus.rsv_en && bus.rsv_idx != 0) pend_m[bus.rsv_idx] = 1'b1;
         err_m = (err_m + sum > 255) ? 255 : err_m + sum;
      end
      cyc++;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin model[i] = 'x; pend_m[i] = 1'b0; end
      err_m = 0;
      idle();
      bus.wa_idx = '0; bus.wa_data = '0; bus.wb_idx = '0; bus.wb_data = '0;
      bus.rsv_idx = '0; bus.rd_idx = '0;

      // Reset, then sweep every index on every port
      reset = 1'b1;
      set_rd(0, 5); set_rd(1, 2);
      cycle();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < NR; k++) set_rd(k, i);
         cycle();
      end

      // Single write, visible next cycle, r2 tap untouched
      bus.wa_en = 1'b1; bus.wa_idx = 5'd5; bus.wa_data = 32'hDEADBEEF;
      set_rd(0, 5); set_rd(1, 2);
      cycle();
      idle(); #1;
      chk("t2_r5", 64'(bus.rd_data[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
      chk("t2_v0", 64'(bus.reg_v0), 64'h0);

      // Dual write collision and disjoint dual write
      bus.wa_en = 1'b1; bus.wa_idx = 5'd7; bus.wa_data = 32'h11;
      bus.wb_en = 1'b1; bus.wb_idx = 5'd7; bus.wb_data = 32'h22;
      cycle();
      idle(); set_rd(0, 7); #1;
      chk("t3_r7", 64'(bus.rd_data[0 +: DW]), 64'h22);
      bus.wa_en = 1'b1; bus.wa_idx = 5'd3; bus.wa_data = 32'h33;
      bus.wb_en = 1'b1; bus.wb_idx = 5'd4; bus.wb_data = 32'h44;
      cycle();
      idle(); set_rd(0, 3); set_rd(1, 4); #1;
      chk("t3_r3", 64'(bus.rd_data[0 +: DW]), 64'h33);
      chk("t3_r4", 64'(bus.rd_data[DW +: DW]), 64'h44);

      // r0 write attempts saturate the error counter
      set_rd(0, 0); set_rd(1, 0);
      repeat (200) begin
         bus.wa_en = 1'b1; bus.wa_idx = '0; bus.wa_data = $urandom;
         bus.wb_en = 1'b1; bus.wb_idx = '0; bus.wb_data = $urandom;
         cycle();
      end
      idle(); #1;
      chk("t4_err_sat", 64'(bus.err_r0_cnt), 64'd255);
      chk("t4_r0", 64'(bus.rd_data[0 +: DW]), 64'h0);

      // Scoreboard: reserve, reserve+write tie, write release
      bus.rsv_en = 1'b1; bus.rsv_idx = 5'd9; set_rd(0, 9); set_rd(1, 9);
      cycle();
      idle(); #1;
      chk("t5_rsv", 64'(bus.rd_pend[0]), 64'h1);
      bus.rsv_en = 1'b1; bus.rsv_idx = 5'd9;
      bus.wb_en = 1'b1; bus.wb_idx = 5'd9; bus.wb_data = 32'h99;
      cycle();
      idle(); #1;
      chk("t5_tie", 64'(bus.rd_pend[0]), 64'h1);
      bus.wb_en = 1'b1; bus.wb_idx = 5'd9; bus.wb_data = 32'h9A;
      cycle();
      idle(); #1;
      chk("t5_release", 64'(bus.rd_pend[1]), 64'h0);

      // Same-cycle read of a register being written
      bus.rsv_en = 1'b1; bus.rsv_idx = 5'd6; cycle(); idle();
      bus.wa_en = 1'b1; bus.wa_idx = 5'd6; bus.wa_data = 32'hAB; set_rd(0, 6); #1;
`ifdef REGFILE_BYPASS_EN
      chk("t6_bypass_data", 64'(bus.rd_data[0 +: DW]), 64'hAB);
      chk("t6_bypass_pend", 64'(bus.rd_pend[0]), 64'h0);
`else
      chk("t6_old_data", 64'(bus.rd_data[0 +: DW]), 64'h0);
      chk("t6_old_pend", 64'(bus.rd_pend[0]), 64'h1);
`endif
      cycle();

      // Random traffic on a narrow index window to provoke collisions, with rare resets
      repeat (400) begin
         reset       = ($urandom_range(0, 59) == 0);
         bus.wa_en   = 1'($urandom_range(0, 1));
         bus.wa_idx  = AW'($urandom_range(0, 7));
         bus.wa_data = $urandom;
         bus.wb_en   = 1'($urandom_range(0, 1));
         bus.wb_idx  = AW'($urandom_range(0, 7));
         bus.wb_data = $urandom;
         bus.rsv_en  = 1'($urandom_range(0, 1));
         bus.rsv_idx = AW'($urandom_range(0, 7));
         for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, 7));
         cycle();
      end
      reset = 1'b0;
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
